// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, widths and address check for the data-memory responder
//
// Purpose: common definitions imported by data_mem_responder and mem_array.
//   state_t    : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W     : data word width in bits
//   addr_legal : 1 when a byte address is word-aligned and inside the array
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Upper address bits take part in the range compare only; they are never
  // dropped to form an aliased index.
  function automatic logic addr_legal(input logic [63:0] addr,
                                      input int unsigned depth_words);
    logic [63:0] limit;
    limit = {32'd0, depth_words} << 2;
    return (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - DEPTH_WORDS x 32 storage, synchronous write, asynchronous read
//
// Purpose: the only storage array of the responder. Contents are not reset.
// Ports:
//   clock  in  1       write clock
//   we     in  1       write enable, word written on the rising edge
//   index  in  IDX_W   word index for both read and write
//   wdata  in  WORD_W  write data
//   rdata  out WORD_W  combinational read of mem[index]
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[index] <= wdata;
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - handshaked, wait-stated data-memory target for CPU loads/stores
//
// Purpose: accepts one load/store at a time, waits WAIT_CYCLES+1 cycles, then
// returns read data or commits the store with a one-cycle ready pulse.
// Illegal (misaligned or out-of-range) addresses complete with err=1 and no write.
// Ports:
//   clock  in  1       system clock
//   reset  in  1       asynchronous active-high reset
//   req    in  1       request valid, held with stable fields until ready
//   we     in  1       1 = store, 0 = load (sampled at acceptance)
//   addr   in  ADDR_W  byte address (sampled at acceptance)
//   wdata  in  32      store data (sampled at acceptance)
//   rdata  out 32      load data during ready of a legal load, else 0
//   ready  out 1       one-cycle completion pulse
//   err    out 1       illegal address, valid with ready
//   busy   out 1       high from the cycle after acceptance through the response cycle
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic              lat_err;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_index;
  logic [WORD_W-1:0] mem_rdata;

  // Storage is touched only from the latched fields, so input changes while
  // busy cannot reach it. The store commits at the end of RESP, before the
  // next request can be accepted.
  assign mem_index = lat_addr[IDX_W+1:2];
  assign mem_we    = (state == RESP) && lat_we && !lat_err;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .index (mem_index),
    .wdata (lat_wdata),
    .rdata (mem_rdata)
  );

  // WAIT always spans WAIT_CYCLES+1 cycles (counter runs WAIT_CYCLES..0), so
  // ready trails the accepting edge by WAIT_CYCLES+1 edges, including the
  // zero-wait case. Errors follow the same path and are never fast-tracked.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_err   <= 1'b0;
      rdata     <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_err   <= !addr_legal(64'(addr), DEPTH_WORDS);
            cnt       <= 4'(WAIT_CYCLES);
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            ready <= 1'b1;
            err   <= lat_err;
            rdata <= (!lat_we && !lat_err) ? mem_rdata : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
